// File: rtl/keypad_matrix_scanner_if.sv
// Keypad-side signals of the matrix scanner: column drive, synchronized
// rows and the decoded key outputs handed to the register logic.
interface keypad_matrix_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad column scanner with press/release debounce.
// Emits {row, col} with a one-cycle strobe per accepted press.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV        = 10000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    keypad_matrix_scanner_if.master kp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        state, state_n;
    logic [SW-1:0] scan_cnt, scan_cnt_n;
    logic [DW-1:0] deb_cnt, deb_cnt_n;
    logic [1:0]    col, col_n;
    logic [1:0]    row, row_n;
    logic [3:0]    code_n;
    logic          valid_n;
    logic          held_n;
    logic [1:0]    low_row;
    logic          row_hit;

    // Lowest-index row wins when several rows are high together.
    always_comb begin
        low_row = 2'd3;
        priority case (1'b1)
            kp.row_in[0]: low_row = 2'd0;
            kp.row_in[1]: low_row = 2'd1;
            kp.row_in[2]: low_row = 2'd2;
            default:      low_row = 2'd3;
        endcase
    end

    assign row_hit = kp.row_in[row];

    always_comb begin
        state_n    = state;
        scan_cnt_n = scan_cnt;
        deb_cnt_n  = deb_cnt;
        col_n      = col;
        row_n      = row;
        code_n     = kp.key_code;
        valid_n    = 1'b0;
        held_n     = kp.key_held;
        unique case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_n = '0;
                    if (|kp.row_in) begin
                        row_n     = low_row;
                        deb_cnt_n = '0;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    scan_cnt_n = scan_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_hit) begin
                    scan_cnt_n = '0;
                    state_n    = SCAN;
                end else if (deb_cnt == DEB_LAST) begin
                    code_n    = {row, col};
                    valid_n   = 1'b1;
                    held_n    = 1'b1;
                    deb_cnt_n = '0;
                    state_n   = HELD;
                end else begin
                    deb_cnt_n = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (row_hit) begin
                    deb_cnt_n = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    held_n     = 1'b0;
                    deb_cnt_n  = '0;
                    scan_cnt_n = '0;
                    col_n      = col + 2'd1;
                    state_n    = SCAN;
                end else begin
                    deb_cnt_n = deb_cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SCAN;
            scan_cnt     <= '0;
            deb_cnt      <= '0;
            col          <= '0;
            row          <= '0;
            kp.col_out   <= 4'b0001;
            kp.key_code  <= 4'h0;
            kp.key_valid <= 1'b0;
            kp.key_held  <= 1'b0;
        end else begin
            state        <= state_n;
            scan_cnt     <= scan_cnt_n;
            deb_cnt      <= deb_cnt_n;
            col          <= col_n;
            row          <= row_n;
            kp.col_out   <= 4'b0001 << col_n;
            kp.key_code  <= code_n;
            kp.key_valid <= valid_n;
            kp.key_held  <= held_n;
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a physical keypad model feeds row_in,
// expected key codes go to a queue and a monitor checks each key_valid.
module tb_keypad_matrix_scanner;
    localparam int SD = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst;

    keypad_matrix_scanner_if kif ();

    keypad_matrix_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // keys[c] = mask of pressed rows in column c
    logic [3:0] keys [4];
    logic [3:0] rows;
    logic [3:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always_comb begin
        rows = 4'b0;
        for (int c = 0; c < 4; c++)
            if (kif.col_out[c]) rows = rows | keys[c];
    end
    assign kif.row_in = rows;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] low_row(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = 2'(i);
        return r;
    endfunction

    function automatic logic [3:0] onehot(input int c);
        return 4'(1 << (c % 4));
    endfunction

    always @(negedge clk) begin
        if (!rst && kif.key_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got key_code %0h, expected no key_valid",
                         kif.key_code);
            end else begin
                chk("key_code", kif.key_code, exp_q.pop_front());
                chk("valid_with_held", kif.key_held, 1);
            end
        end
    end

    task automatic wait_col(input int c, input bit on);
        int n;
        n = 0;
        while (((kif.col_out == onehot(c)) != on) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("col_wait_timeout", n, 0);
    endtask

    task automatic arm(input int c, input logic [3:0] mask);
        wait_col(c, 1'b0);
        keys[c] = mask;
        wait_col(c, 1'b1);
    endtask

    task automatic expect_press(input int c, input logic [3:0] mask,
                                input int lat);
        int n;
        n = 0;
        exp_q.push_back({low_row(mask), 2'(c)});
        while (!kif.key_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("press_latency", n, lat);
        chk("held_rise", kif.key_held, 1);
    endtask

    task automatic hold_release(input int c, input logic [3:0] mask,
                                input logic [3:0] extra, input bit rb);
        logic [3:0] code;
        int last;
        code = {low_row(mask), 2'(c)};
        last = rb ? DB + 7 : DB;
        keys[c] = mask | extra;
        repeat (3) @(negedge clk);
        chk("held_hold", kif.key_held, 1);
        keys[c] = 4'b0;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            if (rb && i == 6) keys[c] = mask;
            if (rb && i == 7) keys[c] = 4'b0;
            if (i == last - 1) chk("held_before_fall", kif.key_held, 1);
        end
        chk("held_fall", kif.key_held, 0);
        chk("col_after_release", kif.col_out, onehot(c + 1));
        chk("code_kept", kif.key_code, code);
    endtask

    task automatic press_trial(input int c, input logic [3:0] mask,
                               input logic [3:0] extra, input bit rb);
        arm(c, mask);
        expect_press(c, mask, SD + DB);
        hold_release(c, mask, extra, rb);
    endtask

    task automatic press_bounce(input int c, input logic [3:0] mask,
                                input int k);
        arm(c, mask);
        repeat (SD + k) @(negedge clk);
        keys[c] = 4'b0;
        for (int i = 1; i <= SD + 1; i++) begin
            @(negedge clk);
            chk("bounce_col", kif.col_out, onehot(i <= SD ? c : c + 1));
        end
        chk("bounce_no_held", kif.key_held, 0);
    endtask

    task automatic reset_mid(input int c, input logic [3:0] mask);
        arm(c, mask);
        repeat (SD + 4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_col", kif.col_out, 4'b0001);
        chk("rst_mid_code", kif.key_code, 4'h0);
        chk("rst_mid_valid", kif.key_valid, 0);
        chk("rst_mid_held", kif.key_held, 0);
        @(negedge clk);
        rst = 1'b0;
        expect_press(c, mask, SD * (c + 1) + DB);
        hold_release(c, mask, 4'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        int kind;
        logic [3:0] m;
        for (int i = 0; i < 4; i++) keys[i] = 4'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_col", kif.col_out, 4'b0001);
            chk("rst_code", kif.key_code, 4'h0);
            chk("rst_valid", kif.key_valid, 0);
            chk("rst_held", kif.key_held, 0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 2 * SD; i++) begin
            @(negedge clk);
            if (i == SD - 1) chk("scan_col0", kif.col_out, 4'b0001);
            if (i == SD) chk("scan_col1", kif.col_out, 4'b0010);
            if (i == 2 * SD) chk("scan_col2", kif.col_out, 4'b0100);
        end

        press_trial(1, 4'b0100, 4'b0000, 1'b0);
        press_bounce(3, 4'b0001, 5);
        press_trial(2, 4'b0010, 4'b0000, 1'b1);
        press_trial(0, 4'b1010, 4'b1000, 1'b0);
        reset_mid($urandom_range(0, 3), onehot($urandom_range(0, 3)));

        for (int t = 0; t < 12; t++) begin
            c = $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            m = onehot($urandom_range(0, 3));
            if (kind == 1) m = 4'($urandom_range(1, 15));
            if (kind == 2)
                press_bounce(c, m, $urandom_range(1, DB - 1));
            else
                press_trial(c, m, kind == 1 ? 4'b1000 : 4'b0000,
                            1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        chk("pending_keys", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

- Scans a 4x4 matrix keypad and debounces key presses and releases.
- Emits a 4-bit key code with a one-cycle valid strobe per accepted press.
- Sits between the two-flop row-line synchronizer and the keypad decode/register logic of the 10 MHz keyboard path.
- Drives the column lines itself and consumes only synchronized row lines; it performs no synchronization of its own.

## Interface
- SCAN_DIV, 10000: clock cycles each column stays driven (1 ms at 10 MHz); must be ≥ 2.
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required to accept a press or a release (10 ms); must be ≥ 2.
- clk  input  1  system clock, 10 MHz.
- rst  input  1  asynchronous, active-high reset.
- row_in  input  4  synchronized row lines; active-high; bit r = row r.
- col_out  output  4  one-hot column drive; active-high; bit c = column c.
- key_code  output  4  {row[1:0], col[1:0]} of the last accepted key; held until the next accepted key.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high while an accepted key has not yet been released.

## Operation
- States: SCAN, DEBOUNCE, HELD.
- SCAN:
  - col_out rotates 0001→0010→0100→1000→0001, advancing when scan_cnt == SCAN_DIV-1.
  - scan_cnt then wraps to 0.
  - Row sampling happens only on the cycle where scan_cnt == SCAN_DIV-1.
  - If any row_in bit is high on that cycle: latch the column index and the lowest-index high row, then go to DEBOUNCE.
  - On that transition col_out does not advance (it freezes on the sampled column) and deb_cnt is cleared to 0.
- DEBOUNCE:
  - col_out stays frozen.
  - Each cycle with row_in[latched_row] == 1: deb_cnt increments.
  - If row_in[latched_row] == 0: return to SCAN on the same column with scan_cnt = 0. No output change.
  - On the cycle where deb_cnt == DEBOUNCE_CYCLES-1 and the row is still high:
    - load key_code = {latched_row, latched_col};
    - pulse key_valid;
    - set key_held;
    - go to HELD with deb_cnt = 0.
- HELD:
  - col_out stays frozen.
  - Row low: deb_cnt increments. Row high: deb_cnt is cleared to 0.
  - On the cycle where deb_cnt == DEBOUNCE_CYCLES-1 and the row is low:
    - clear key_held;
    - go to SCAN with scan_cnt = 0;
    - col_out advances to the next column.
- Other rows going high in DEBOUNCE or HELD are ignored. There is no rollover and no second key.
- Multiple rows high at the sampling instant: the lowest row index wins.
- key_code is unchanged by reset-free operation except on acceptance.
- Counter widths: $clog2 of the respective parameter. No overflow is possible, because the counters wrap or clear at their terminal value.

## Timing
- Reset values: col_out = 4'b0001, key_code = 4'h0, key_valid = 0, key_held = 0, state = SCAN, all counters 0.
- Reset asserted mid-debounce or in HELD: all outputs return to reset values immediately (asynchronously). No key_valid is emitted.
- All outputs are registered; there are no combinational paths from row_in.
- Press latency: with a stable press, key_valid is high in the cycle after the DEBOUNCE_CYCLES-th rising edge following the sampling edge.
- key_held rises in the same cycle as key_valid.
- key_valid is exactly one cycle wide. At most one pulse is produced per press, regardless of hold duration.
- Release latency: key_held falls DEBOUNCE_CYCLES edges after the first low cycle of an uninterrupted low run.
- Worst-case detection delay before debounce starts: 4 × SCAN_DIV cycles.

## Test plan
Parameters for all scenarios: SCAN_DIV = 4, DEBOUNCE_CYCLES = 8.
- Reset behaviour: assert rst for 3 cycles, then release.
  - During reset: col_out = 0001, key_code = 0, key_valid = 0, key_held = 0.
  - After release: col_out shows 0010 after 4 cycles and 0100 after 8 cycles.
- Clean press of row 2 while column 1 is driven: hold row_in = 0100 when col_out = 0010.
  - key_valid pulses once, 8 edges after the sample.
  - key_code = 4'b1001; key_held = 1.
- Bounce on press: drive row 0 high on column 3, drop it low after 5 debounce cycles.
  - No key_valid.
  - Scanner resumes on column 3 (col_out = 1000 for 4 cycles, then 0001).
- Release with bounce: after a press is accepted, go low 6 cycles, high 1 cycle, then low 8 cycles.
  - key_held stays 1 until the 8th edge of the final low run, then falls.
  - col_out advances; key_code stays unchanged.
- Multiple rows at the sampling instant: row_in = 1010 on column 0.
  - key_code = 4'b0100 (row 1 wins).
  - Raising row 3 during HELD has no effect.
- Reset mid-operation: assert rst at debounce cycle 4.
  - Outputs are at reset values immediately.
  - No key_valid after release, even if row_in stays high; a new press needs a fresh scan and a full debounce.
